motor_speed_ramp: RTL
=====================

// Module: motor_speed_ramp
// PURPOSE
//  Upstream command stage for the per-H-bridge motor_controller instances.
//  Accepts signed speed commands per channel over a valid/ready handshake, slew-limits
//  each channel toward its target, and drives locked-antiphase duty_cycle/on to the
//  controllers. The controllers' dir inputs are tied high at instantiation.
//  A command watchdog ramps all motors to zero when the host stops talking.
// PARAMETERS
//  NUM_MOTORS  4           channels served; must be >= 1
//  RAMP_DIV    1000        clk cycles per ramp tick; must be > NUM_MOTORS
//  STEP        1           max |speed| change per channel per tick, unsigned
//  WDT_CYCLES  50000000    idle cycles before watchdog trip (1 s at 50 MHz)
// PORTS
//  clk         in   1        system clock, all logic posedge
//  reset_n     in   1        asynchronous, active-low reset
//  enable_in   in   1        global motor enable; low = immediate stop
//  period_in   in   16       PWM period, shared with the motor_controllers
//  cmd_valid   in   1        command present
//  cmd_ready   out  1        stage can accept; transfer on valid & ready
//  cmd_chan    in   $clog2(NUM_MOTORS) (min 1)  target channel index
//  cmd_speed   in   16       signed two's-complement target speed
//  wdt_clear   in   1        single-cycle pulse, clears watchdog trip
//  wdt_tripped out  1        sticky watchdog status
//  on_out      out  NUM_MOTORS       per-channel on, to motor_controller.on
//  duty_out    out  16*NUM_MOTORS    per-channel duty, ch i at [16*i+:16]
//  at_target   out  NUM_MOTORS       cur[i] == target[i]
// BEHAVIOUR
//  Reset: target[i]=0, cur[i]=0, on_out=0, duty_out=0, at_target=all 1,
//    wdt_tripped=0, cmd_ready=0, FSM=IDLE, prescaler=0, watchdog count=0.
//  Clamp: half = period_in>>1. Accepted speed is clamped to [-half, +half] before storage.
//    cur is also clamped to this range every clock, so a shrinking period_in takes effect.
//  Output, registered with 1-cycle latency from cur: duty_out[i] = half + cur[i],
//    as 16-bit unsigned.
//  FSM IDLE: cmd_ready=1 (registered; 1 in cycle after reset release).
//    Prescaler counts 0..RAMP_DIV-1. At wrap -> SWEEP with idx=0, cmd_ready=0 next cycle.
//  FSM SWEEP: one channel per cycle. cur[idx] moves toward target[idx] by
//    min(STEP, |target-cur|). Signed 17-bit intermediate, no overflow.
//    idx==NUM_MOTORS-1 -> IDLE. The prescaler keeps counting during SWEEP.
//  Accept (valid & ready): if cmd_chan < NUM_MOTORS, target[chan] <= clamped speed,
//    next cycle, and the watchdog count is reset. Out-of-range chan: handshake completes,
//    data is dropped, watchdog is not kicked.
//  Watchdog: count increments in every cycle with no in-range accept.
//    count == WDT_CYCLES-1 sets wdt_tripped. While tripped, all targets are forced to 0
//    and accepts complete but are discarded, so normal ramp-down continues.
//    on_out[i] falls when cur[i]==0.
//  wdt_clear: clears wdt_tripped and count. Targets stay 0 until new commands arrive.
//    If clear coincides with the trip condition, clear wins.
//  enable_in low: next cycle on_out=0, all cur and target =0, FSM->IDLE, prescaler=0.
//    Watchdog is unaffected.
//  on_out[i] = enable_in & ~(wdt_tripped & cur[i]==0), registered.
//  Simultaneous accept and SWEEP write to the same channel cannot occur:
//    accept happens only in IDLE.
//  Reset asserted mid-SWEEP: all state returns to reset values asynchronously.
// STRUCTURE
//  Shared constants go into defines.v alongside PERIOD_LENGTH:
//    `RAMP_DIV_DEFAULT, `WDT_CYCLES_DEFAULT, `SPEED_WIDTH (16).
//  One sub-module: motor_cmd_watchdog (counter, sticky trip, clear; ports clk, reset_n,
//    kick, clear, tripped). The ramp FSM, prescaler and per-channel arrays stay in the
//    top module.
// TESTING
//  1. Reset, period_in=1000, enable=1, RAMP_DIV=10, STEP=5, cmd ch0=+100 ->
//     duty_out[0] climbs 500,505,..,600 one step per tick; at_target[0]=1 at 600.
//  2. Cmd ch1=+50 then -50 mid-ramp -> cur passes through 0 (duty 500) and settles at
//     duty 450; on_out[1] stays 1 throughout.
//  3. Cmd speed=+32767 with period_in=1000 -> target clamps to 500 (duty 1000).
//     Then period_in=600 -> duty_out[0]=600 within 2 cycles.
//  4. Hold cmd_valid across a tick -> cmd_ready low exactly NUM_MOTORS cycles.
//     No command is lost or duplicated.
//  5. WDT_CYCLES=200, no cmds -> wdt_tripped=1 at cycle 200, all channels ramp to duty
//     half, on_out drops per channel at cur==0. Cmds are ignored until wdt_clear.
//  6. enable_in low mid-ramp -> on_out=0 and duty_out=half next cycle.
//     Out-of-range cmd_chan is accepted and does not kick the watchdog.

Source files
------------

// File: rtl/motor_speed_ramp_pkg.sv
// Shared constants, FSM state type and speed arithmetic helpers for the motor ramp stage.
package motor_speed_ramp_pkg;

  localparam int unsigned SPEED_WIDTH        = 16;
  localparam int unsigned RAMP_DIV_DEFAULT   = 1000;
  localparam int unsigned WDT_CYCLES_DEFAULT = 50000000;

  typedef enum logic [0:0] {
    StIdle,
    StSweep
  } ramp_state_e;

  // Clamp a signed 17-bit speed into [-half, +half]; the result always fits 16 bits.
  function automatic logic signed [15:0] clamp_speed(input logic signed [16:0] val,
                                                     input logic [15:0]        half);
    logic signed [16:0] hi;
    logic signed [16:0] lo;
    hi = {1'b0, half};
    lo = -hi;
    if (val > hi) return hi[15:0];
    if (val < lo) return lo[15:0];
    return val[15:0];
  endfunction

  // Move cur toward tgt by at most step; 17-bit math so the difference cannot overflow.
  function automatic logic signed [16:0] step_toward(input logic signed [15:0] cur,
                                                     input logic signed [15:0] tgt,
                                                     input logic signed [16:0] step);
    logic signed [16:0] c;
    logic signed [16:0] t;
    logic signed [16:0] diff;
    c    = {cur[15], cur};
    t    = {tgt[15], tgt};
    diff = t - c;
    if (diff > step) return c + step;
    if (diff < -step) return c - step;
    return t;
  endfunction

endpackage

// File: rtl/motor_cmd_watchdog.sv
// Command watchdog: counts idle cycles, raises a sticky trip, cleared by a pulse.
module motor_cmd_watchdog
  import motor_speed_ramp_pkg::*;
#(
  parameter int unsigned WDT_CYCLES = WDT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic kick,
  input  logic clear,
  output logic tripped
);

  localparam int unsigned CntW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WDT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tripped_q, tripped_d;

  // Next-state: clear beats a coincident trip; the count holds while tripped.
  always_comb begin
    cnt_d     = cnt_q;
    tripped_d = tripped_q;
    if (clear) begin
      cnt_d     = '0;
      tripped_d = 1'b0;
    end else if (kick) begin
      cnt_d = '0;
    end else if (!tripped_q) begin
      if (cnt_q == CntLast) begin
        tripped_d = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Counter and sticky trip registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      tripped_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tripped_q <= tripped_d;
    end
  end

  assign tripped = tripped_q;

endmodule

// File: rtl/motor_speed_ramp.sv
// Per-channel slew-limited speed command stage feeding the locked-antiphase motor controllers.
module motor_speed_ramp
  import motor_speed_ramp_pkg::*;
#(
  parameter int unsigned NUM_MOTORS = 4,
  parameter int unsigned RAMP_DIV   = RAMP_DIV_DEFAULT,
  parameter int unsigned STEP       = 1,
  parameter int unsigned WDT_CYCLES = WDT_CYCLES_DEFAULT,
  localparam int unsigned CHW       = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              enable_in,
  input  logic [SPEED_WIDTH-1:0]            period_in,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [CHW-1:0]                    cmd_chan,
  input  logic [SPEED_WIDTH-1:0]            cmd_speed,
  input  logic                              wdt_clear,
  output logic                              wdt_tripped,
  output logic [NUM_MOTORS-1:0]             on_out,
  output logic [SPEED_WIDTH*NUM_MOTORS-1:0] duty_out,
  output logic [NUM_MOTORS-1:0]             at_target
);

  localparam int unsigned PW = $clog2(RAMP_DIV);
  localparam logic [PW-1:0]  PrescLast = PW'(RAMP_DIV - 1);
  localparam logic [CHW-1:0] IdxLast   = CHW'(NUM_MOTORS - 1);
  localparam logic [CHW:0]   NumChan   = (CHW + 1)'(NUM_MOTORS);
  localparam logic signed [16:0] StepS = 17'(STEP);

  ramp_state_e       state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [CHW-1:0]    idx_q, idx_d;
  logic              ready_q, ready_d;

  logic signed [15:0] cur_q  [NUM_MOTORS];
  logic signed [15:0] cur_d  [NUM_MOTORS];
  logic signed [15:0] tgt_q  [NUM_MOTORS];
  logic signed [15:0] tgt_d  [NUM_MOTORS];
  logic [15:0]        duty_q [NUM_MOTORS];
  logic [15:0]        duty_d [NUM_MOTORS];
  logic [NUM_MOTORS-1:0] on_q, on_d;

  logic [15:0] half;
  logic        in_range;
  logic        kick;

  assign half     = period_in >> 1;
  assign in_range = ({1'b0, cmd_chan} < NumChan);
  // Only an in-range accept that actually updates a target counts as host activity.
  assign kick     = cmd_valid & ready_q & in_range & ~wdt_tripped;

  motor_cmd_watchdog #(
    .WDT_CYCLES(WDT_CYCLES)
  ) u_wdt (
    .clk    (clk),
    .reset_n(reset_n),
    .kick   (kick),
    .clear  (wdt_clear),
    .tripped(wdt_tripped)
  );

  // Ramp FSM: free-running prescaler launches a one-channel-per-cycle sweep on wrap.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    presc_d = (presc_q == PrescLast) ? '0 : presc_q + PW'(1);
    unique case (state_q)
      StIdle: begin
        if (presc_q == PrescLast) begin
          state_d = StSweep;
          idx_d   = '0;
        end
      end
      StSweep: begin
        if (idx_q == IdxLast) state_d = StIdle;
        else                  idx_d   = idx_q + CHW'(1);
      end
      default: state_d = StIdle;
    endcase
    if (!enable_in) begin
      state_d = StIdle;
      presc_d = '0;
      idx_d   = '0;
    end
    ready_d = (state_d == StIdle);
  end

  // Per-channel next state: clamp, optional sweep step, target writes and output encoding.
  always_comb begin
    for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
      logic signed [15:0] cur_lim;
      logic signed [16:0] nxt;
      cur_lim = clamp_speed({cur_q[i][15], cur_q[i]}, half);
      nxt     = {cur_lim[15], cur_lim};
      if (state_q == StSweep && idx_q == CHW'(i)) nxt = step_toward(cur_lim, tgt_q[i], StepS);
      cur_d[i]  = clamp_speed(nxt, half);
      tgt_d[i]  = tgt_q[i];
      if (kick && cmd_chan == CHW'(i)) tgt_d[i] = clamp_speed({cmd_speed[15], cmd_speed}, half);
      if (wdt_tripped) tgt_d[i] = '0;
      // Clamped cur keeps the duty inside the new period as soon as it shrinks.
      duty_d[i] = half + $unsigned(cur_lim);
      on_d[i]   = enable_in & ~(wdt_tripped & (cur_q[i] == '0));
      if (!enable_in) begin
        cur_d[i]  = '0;
        tgt_d[i]  = '0;
        duty_d[i] = half;
      end
    end
  end

  // FSM, prescaler and handshake registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      presc_q <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  // Per-channel speed, target and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
        cur_q[i]  <= '0;
        tgt_q[i]  <= '0;
        duty_q[i] <= '0;
      end
      on_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
        cur_q[i]  <= cur_d[i];
        tgt_q[i]  <= tgt_d[i];
        duty_q[i] <= duty_d[i];
      end
      on_q <= on_d;
    end
  end

  // Output packing and target comparison.
  always_comb begin
    for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
      duty_out[16*i +: 16] = duty_q[i];
      at_target[i]         = (cur_q[i] == tgt_q[i]);
    end
  end

  assign cmd_ready = ready_q;
  assign on_out    = on_q;

endmodule
